mem_port_responder: RTL and testbench
=====================================

MEM_PORT_RESPONDER -- requirements
Module: mem_port_responder

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 2, meaning the maximum number of consecutive data-port grants allowed while an instruction request is pending.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port mem_addr1, input, 16 bits: instruction-port word address.
REQ-005 The block SHALL have port mem_read1, input, 1 bit: instruction-port read request.
REQ-006 The block SHALL have port mem_rdata1, output, 16 bits: instruction-port read data.
REQ-007 The block SHALL have port mem_resp1, output, 1 bit: instruction-port completion pulse.
REQ-008 The block SHALL have port mem_addr2, input, 16 bits: data-port address.
REQ-009 The block SHALL have ports mem_read2 and mem_write2, inputs, 1 bit each: data-port read and write requests.
REQ-010 The block SHALL have port mem_wdata2, input, 16 bits: data-port write data.
REQ-011 The block SHALL have port mem_rdata2, output, 16 bits: data-port read data.
REQ-012 The block SHALL have port mem_resp2, output, 1 bit: data-port completion pulse.
REQ-013 The block SHALL have port pmem_addr, output, 16 bits: backing-memory address.
REQ-014 The block SHALL have ports pmem_read and pmem_write, outputs, 1 bit each: backing-memory read and write strobes.
REQ-015 The block SHALL have port pmem_wdata, output, 16 bits, and port pmem_rdata, input, 16 bits: backing-memory write and read data.
REQ-016 The block SHALL have port pmem_resp, input, 1 bit: backing-memory completion, any latency of 1 cycle or more.

Function
REQ-017 FSM states SHALL be IDLE, SERVE_I and SERVE_D.
REQ-018 IDLE SHALL grant on a pending request, latch the address, latch write data and operation, and move to SERVE_I or SERVE_D on the next edge.
REQ-019 IDLE with no pending request SHALL remain in IDLE.
REQ-020 Simultaneous I and D requests SHALL grant D, unless the starve counter equals STARVE_LIMIT, in which case I SHALL be granted.
REQ-021 The starve counter SHALL increment on each D grant made while mem_read1 is high, SHALL clear on any I grant, and SHALL saturate at STARVE_LIMIT.
REQ-022 mem_read2 and mem_write2 asserted together SHALL be treated as a write.
REQ-023 In SERVE_x, pmem_addr, pmem_wdata and pmem_read/pmem_write SHALL be driven from latched values only and held constant until pmem_resp.
REQ-024 Requester input changes mid-transaction SHALL NOT affect the transaction in flight.
REQ-025 On the pmem_resp cycle the block SHALL register pmem_rdata into mem_rdata1 (SERVE_I) or mem_rdata2 (SERVE_D read).
REQ-026 On the pmem_resp cycle the block SHALL pulse the matching mem_resp for exactly one cycle on the following cycle and return to IDLE.
REQ-027 A write SHALL leave mem_rdata2 unchanged.
REQ-028 Latency SHALL be: request sampled in IDLE at edge N; strobe high from N+1; pmem_resp at edge M; mem_respx high during cycle M+1. Minimum request-to-response latency is 2 cycles.
REQ-029 The earliest new grant after a response SHALL be at edge M+1, because IDLE samples during the response cycle.
REQ-030 A requester SHALL hold its request until mem_resp; a request still high in the response cycle is a new request.
REQ-031 A request deasserted before response SHALL still complete, and its mem_resp SHALL still pulse.
REQ-032 pmem_read and pmem_write SHALL never be high simultaneously and SHALL be low in IDLE.
REQ-033 mem_rdata1 and mem_rdata2 SHALL hold their last value until overwritten.
REQ-034 pmem_resp arriving in IDLE SHALL be ignored.

Reset
REQ-035 reset_n low SHALL immediately, without waiting for clk, force state IDLE, starve counter 0, pmem_read, pmem_write, mem_resp1 and mem_resp2 to 0, and pmem_addr, pmem_wdata, mem_rdata1 and mem_rdata2 to 16'h0000.
REQ-036 Reset mid-transaction SHALL abandon the transaction with no response; the first grant SHALL be on the first edge after reset_n rises.

Verification
REQ-037 The bench SHALL cover: I read x1000, pmem returns x1234 after 3 cycles -> mem_resp1 one-cycle pulse, mem_rdata1 = x1234, pmem_read high for exactly 3 cycles.
REQ-038 The bench SHALL cover: D write addr x2002, data xBEEF -> pmem_write with pmem_addr = x2002 and pmem_wdata = xBEEF, mem_resp2 pulse, mem_rdata2 unchanged.
REQ-039 The bench SHALL cover: I and D requesting continuously with STARVE_LIMIT = 2 -> grant order D, D, I, D, D, I.
REQ-040 The bench SHALL cover: mem_read2 and mem_write2 both high -> pmem_write only, never pmem_read.
REQ-041 The bench SHALL cover: reset_n dropped mid-read before pmem_resp -> pmem_read low within the same cycle, no mem_resp, and a fresh request served normally after release.
REQ-042 The bench SHALL cover: addresses changed mid-transaction -> pmem_addr stays at the latched value until pmem_resp.

Source files
------------

// File: rtl/mem_port_responder.sv
// Two-port (instruction/data) to single backing-memory arbiter. Serves one
// transaction at a time; data port wins ties unless the instruction port is starved.
module mem_port_responder #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] mem_addr1,
    input  logic        mem_read1,
    output logic [15:0] mem_rdata1,
    output logic        mem_resp1,
    input  logic [15:0] mem_addr2,
    input  logic        mem_read2,
    input  logic        mem_write2,
    input  logic [15:0] mem_wdata2,
    output logic [15:0] mem_rdata2,
    output logic        mem_resp2,
    output logic [15:0] pmem_addr,
    output logic        pmem_read,
    output logic        pmem_write,
    output logic [15:0] pmem_wdata,
    input  logic [15:0] pmem_rdata,
    input  logic        pmem_resp
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [SW-1:0]   r_starve;
    logic            r_is_write;
    logic            w_req_i;
    logic            w_req_d;
    logic            w_grant_i;
    logic            w_grant_d;
    logic            w_done;

    assign w_req_i = mem_read1;
    assign w_req_d = mem_read2 | mem_write2;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Arbitration and next-state decode
    always_comb begin
        w_state_next = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_i && (!w_req_d || (r_starve == LIMIT))) begin
                    w_grant_i    = 1'b1;
                    w_state_next = SERVE_I;
                end else if (w_req_d) begin
                    w_grant_d    = 1'b1;
                    w_state_next = SERVE_D;
                end else begin
                    w_state_next = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_state_next = r_state;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Latched request, backing-memory strobes, starve counter and responses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve   <= {SW{1'b0}};
            r_is_write <= 1'b0;
            pmem_addr  <= 16'h0000;
            pmem_wdata <= 16'h0000;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            mem_rdata1 <= 16'h0000;
            mem_rdata2 <= 16'h0000;
            mem_resp1  <= 1'b0;
            mem_resp2  <= 1'b0;
        end else begin
            mem_resp1 <= 1'b0;
            mem_resp2 <= 1'b0;
            if (w_grant_i) begin
                pmem_addr  <= mem_addr1;
                pmem_read  <= 1'b1;
                pmem_write <= 1'b0;
                r_is_write <= 1'b0;
                r_starve   <= {SW{1'b0}};
            end else if (w_grant_d) begin
                // A simultaneous read+write request is a write
                pmem_addr  <= mem_addr2;
                pmem_wdata <= mem_wdata2;
                pmem_read  <= ~mem_write2;
                pmem_write <= mem_write2;
                r_is_write <= mem_write2;
                if (mem_read1 && (r_starve != LIMIT)) begin
                    r_starve <= r_starve + SW'(1);
                end
            end else if (w_done) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
                if (r_state == SERVE_I) begin
                    mem_rdata1 <= pmem_rdata;
                    mem_resp1  <= 1'b1;
                end else begin
                    if (!r_is_write) begin
                        mem_rdata2 <= pmem_rdata;
                    end
                    mem_resp2 <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed and randomized bench for mem_port_responder with a transaction-level
// reference model (expected read-data registers, strobe counts, grant order).
module tb_mem_port_responder;

    localparam int STARVE = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] mem_addr1 = 16'h0000;
    logic        mem_read1 = 1'b0;
    logic [15:0] mem_rdata1;
    logic        mem_resp1;
    logic [15:0] mem_addr2 = 16'h0000;
    logic        mem_read2 = 1'b0;
    logic        mem_write2 = 1'b0;
    logic [15:0] mem_wdata2 = 16'h0000;
    logic [15:0] mem_rdata2;
    logic        mem_resp2;
    logic [15:0] pmem_addr;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata = 16'h0000;
    logic        pmem_resp = 1'b0;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] exp_rdata1 = 16'h0000;
    logic [15:0] exp_rdata2 = 16'h0000;

    mem_port_responder #(.STARVE_LIMIT(STARVE)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mem_addr1  (mem_addr1),
        .mem_read1  (mem_read1),
        .mem_rdata1 (mem_rdata1),
        .mem_resp1  (mem_resp1),
        .mem_addr2  (mem_addr2),
        .mem_read2  (mem_read2),
        .mem_write2 (mem_write2),
        .mem_wdata2 (mem_wdata2),
        .mem_rdata2 (mem_rdata2),
        .mem_resp2  (mem_resp2),
        .pmem_addr  (pmem_addr),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One complete transaction; the request is dropped right after the grant
    // and the requester inputs are scrambled while the transaction is in flight.
    task automatic txn(input bit is_i, input bit rd2, input bit wr2,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input int lat, input logic [15:0] rdata);
        bit exp_wr;
        int hi;
        exp_wr = !is_i && wr2;
        @(negedge clk);
        mem_addr1  = is_i ? addr : 16'($urandom);
        mem_addr2  = is_i ? 16'($urandom) : addr;
        mem_wdata2 = wdata;
        mem_read1  = is_i;
        mem_read2  = !is_i && rd2;
        mem_write2 = !is_i && wr2;
        @(negedge clk);
        mem_read1  = 1'b0;
        mem_read2  = 1'b0;
        mem_write2 = 1'b0;
        mem_wdata2 = 16'($urandom);
        hi = 0;
        for (int k = 0; k < lat; k++) begin
            if (k > 0) @(negedge clk);
            if (pmem_read || pmem_write) hi++;
            chk1("pmem_read", pmem_read, !exp_wr);
            chk1("pmem_write", pmem_write, exp_wr);
            chk16("pmem_addr", pmem_addr, addr);
            if (exp_wr) chk16("pmem_wdata", pmem_wdata, wdata);
            chk1("resp_early", mem_resp1 | mem_resp2, 1'b0);
            mem_addr1  = 16'($urandom);
            mem_addr2  = 16'($urandom);
            pmem_rdata = 16'($urandom);
        end
        pmem_resp  = 1'b1;
        pmem_rdata = rdata;
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = 16'($urandom);
        if (is_i) exp_rdata1 = rdata;
        else if (!exp_wr) exp_rdata2 = rdata;
        chk_int("strobe_cycles", hi, lat);
        chk1("mem_resp1", mem_resp1, is_i);
        chk1("mem_resp2", mem_resp2, !is_i);
        chk16("mem_rdata1", mem_rdata1, exp_rdata1);
        chk16("mem_rdata2", mem_rdata2, exp_rdata2);
        chk1("strobe_after", pmem_read | pmem_write, 1'b0);
        @(negedge clk);
        chk1("resp_one_cycle", mem_resp1 | mem_resp2, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_rdata1 = 16'h0000;
        exp_rdata2 = 16'h0000;
    endtask

    initial begin
        bit          found;
        int          dcount;
        logic [15:0] exp_addr;
        logic [15:0] v;
        bit          ri;
        bit          rr;
        bit          rw;

        // Reset values
        repeat (2) @(negedge clk);
        chk1("rst_pmem_read", pmem_read, 1'b0);
        chk1("rst_pmem_write", pmem_write, 1'b0);
        chk1("rst_resp", mem_resp1 | mem_resp2, 1'b0);
        chk16("rst_pmem_addr", pmem_addr, 16'h0000);
        chk16("rst_pmem_wdata", pmem_wdata, 16'h0000);
        chk16("rst_rdata1", mem_rdata1, 16'h0000);
        chk16("rst_rdata2", mem_rdata2, 16'h0000);
        reset_n = 1'b1;

        // Instruction read, 3-cycle memory
        txn(1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 3, 16'h1234);
        chk16("i_read_data", mem_rdata1, 16'h1234);
        // Data read so the following writes have something to preserve
        txn(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'h5A5A);
        // Data write
        txn(1'b0, 1'b0, 1'b1, 16'h2002, 16'hBEEF, 2, 16'h7777);
        chk16("write_keeps_rdata2", mem_rdata2, 16'h5A5A);
        // Read and write together behave as a write
        txn(1'b0, 1'b1, 1'b1, 16'h3004, 16'hA5A5, 4, 16'h0F0F);

        // Memory response while idle is ignored
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = 16'hDEAD;
        @(negedge clk);
        pmem_resp = 1'b0;
        chk1("idle_resp_ignored", mem_resp1 | mem_resp2, 1'b0);
        chk1("idle_no_strobe", pmem_read | pmem_write, 1'b0);
        chk16("idle_rdata1", mem_rdata1, exp_rdata1);
        chk16("idle_rdata2", mem_rdata2, exp_rdata2);

        // Reset in the middle of a read abandons it
        @(negedge clk);
        mem_read1 = 1'b1;
        mem_addr1 = 16'h4444;
        @(negedge clk);
        mem_read1 = 1'b0;
        chk1("mid_read_strobe", pmem_read, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk1("async_rst_read", pmem_read, 1'b0);
        chk16("async_rst_addr", pmem_addr, 16'h0000);
        chk16("async_rst_rdata1", mem_rdata1, 16'h0000);
        exp_rdata1 = 16'h0000;
        exp_rdata2 = 16'h0000;
        pmem_resp  = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        reset_n   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("abandoned_no_resp", mem_resp1 | mem_resp2, 1'b0);
            chk1("abandoned_no_strobe", pmem_read | pmem_write, 1'b0);
        end
        txn(1'b1, 1'b0, 1'b0, 16'h1000, 16'h0000, 2, 16'hC0DE);

        // Continuous I and D requests: starvation-limited grant order
        do_reset();
        @(negedge clk);
        mem_read1  = 1'b1;
        mem_addr1  = 16'h1111;
        mem_read2  = 1'b1;
        mem_write2 = 1'b0;
        mem_addr2  = 16'h2222;
        dcount = 0;
        for (int g = 0; g < 6; g++) begin
            found = 1'b0;
            for (int w = 0; w < 4 && !found; w++) begin
                @(negedge clk);
                if (pmem_read || pmem_write) found = 1'b1;
            end
            chk1("arb_grant_timeout", found, 1'b1);
            if (dcount == STARVE) begin
                exp_addr = 16'h1111;
                dcount = 0;
            end else begin
                exp_addr = 16'h2222;
                dcount++;
            end
            chk16("arb_order", pmem_addr, exp_addr);
            v = 16'($urandom);
            pmem_resp  = 1'b1;
            pmem_rdata = v;
            @(negedge clk);
            pmem_resp = 1'b0;
            if (g == 5) begin
                mem_read1 = 1'b0;
                mem_read2 = 1'b0;
            end
            if (exp_addr == 16'h1111) exp_rdata1 = v;
            else exp_rdata2 = v;
            chk1("arb_resp1", mem_resp1, exp_addr == 16'h1111);
            chk1("arb_resp2", mem_resp2, exp_addr == 16'h2222);
            chk16("arb_rdata1", mem_rdata1, exp_rdata1);
            chk16("arb_rdata2", mem_rdata2, exp_rdata2);
        end
        @(negedge clk);
        chk1("arb_drained", pmem_read | pmem_write, 1'b0);

        // Randomized single-requester transactions
        for (int t = 0; t < 20; t++) begin
            ri = 1'($urandom);
            rr = 1'($urandom);
            rw = 1'($urandom);
            if (!rr && !rw) rr = 1'b1;
            txn(ri, rr, rw, 16'($urandom), 16'($urandom),
                int'($urandom_range(1, 4)), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
